// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  localparam int                  FUNC3_W    = 3;
  localparam logic [FUNC3_W-1:0]  FUNC3_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module mem_arb_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and load/store,
// with data priority, an anti-starvation limit, fetch squash and a response timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DM_BURST = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               If_Req,
  input  logic [ADDR_W-1:0]  If_Addr,
  input  logic               If_Flush,
  output logic [DATA_W-1:0]  If_Rdata,
  output logic               If_Valid,
  input  logic               Dm_Req,
  input  logic               Dm_We,
  input  logic [FUNC3_W-1:0] Dm_Func3,
  input  logic [ADDR_W-1:0]  Dm_Addr,
  input  logic [DATA_W-1:0]  Dm_Wdata,
  output logic [DATA_W-1:0]  Dm_Rdata,
  output logic               Dm_Valid,
  output logic               Mem_Req,
  output logic               Mem_We,
  output logic [FUNC3_W-1:0] Mem_Func3,
  output logic [ADDR_W-1:0]  Mem_Addr,
  output logic [DATA_W-1:0]  Mem_Wdata,
  input  logic               Mem_Ready,
  input  logic [DATA_W-1:0]  Mem_Rdata,
  output logic               Stall_Pipe,
  output logic               Bus_Err
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int STV_W = $clog2(MAX_DM_BURST + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_DM_BURST);

  arb_state_e       state_q, state_d;
  logic [STV_W-1:0] starve_q;
  logic             squash_q;
  logic             busy, done, timeout, tmr_expire;
  logic             turnaround, if_elig, dm_elig;
  logic             grant, grant_owner;

  // The completion cycle is a turnaround: no grant while either Valid is high, so a
  // requester that keeps Req up cannot be granted twice for one access.
  assign turnaround = If_Valid | Dm_Valid;
  assign if_elig    = If_Req & ~If_Flush & ~turnaround;
  assign dm_elig    = Dm_Req & ~turnaround;

  assign busy    = (state_q != IDLE);
  assign done    = busy & Mem_Ready;
  assign timeout = busy & ~Mem_Ready & tmr_expire;

  mem_arb_timer #(.WIDTH(TMR_W)) u_timer (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (grant),
    .load_val (TMR_LOAD),
    .en       (busy),
    .expire   (tmr_expire)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    grant_owner = OWNER_DM;
    unique case (state_q)
      IDLE: begin
        if (if_elig && (!dm_elig || starve_q == STV_MAX)) begin
          grant       = 1'b1;
          grant_owner = OWNER_IF;
          state_d     = BUSY_IF;
        end else if (dm_elig) begin
          grant   = 1'b1;
          state_d = BUSY_DM;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (done || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (!If_Req || (grant && grant_owner == OWNER_IF)) begin
          starve_q <= '0;
        end else if (grant && starve_q != STV_MAX) begin
          starve_q <= starve_q + STV_W'(1);
        end
      end
      if (state_q == BUSY_IF) begin
        if (Mem_Ready || timeout) squash_q <= 1'b0;
        else if (If_Flush)        squash_q <= 1'b1;
      end
    end
  end

  // NOTE: the datapath registers are reset as well, so every output reads 0 during reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Mem_Addr  <= '0;
      Mem_We    <= 1'b0;
      Mem_Func3 <= '0;
      Mem_Wdata <= '0;
      If_Rdata  <= '0;
      Dm_Rdata  <= '0;
      If_Valid  <= 1'b0;
      Dm_Valid  <= 1'b0;
      Bus_Err   <= 1'b0;
    end else begin
      if (grant) begin
        if (grant_owner == OWNER_IF) begin
          Mem_Addr  <= If_Addr;
          Mem_We    <= 1'b0;
          Mem_Func3 <= FUNC3_WORD;
          Mem_Wdata <= '0;
        end else begin
          Mem_Addr  <= Dm_Addr;
          Mem_We    <= Dm_We;
          Mem_Func3 <= Dm_Func3;
          Mem_Wdata <= Dm_We ? Dm_Wdata : '0;
        end
      end
      if (state_q == BUSY_IF && Mem_Ready) If_Rdata <= Mem_Rdata;
      if (state_q == BUSY_DM && Mem_Ready) Dm_Rdata <= Mem_Rdata;
      // A flush arriving together with Mem_Ready still squashes the fetch.
      If_Valid <= (state_q == BUSY_IF) & Mem_Ready & ~squash_q & ~If_Flush;
      Dm_Valid <= (state_q == BUSY_DM) & Mem_Ready;
      Bus_Err  <= timeout;
    end
  end

  assign Mem_Req = busy;

  // Gated by Reset so the stall also reads 0 while the core is held in reset.
  assign Stall_Pipe = Reset & ((If_Req & ~If_Valid) | (Dm_Req & ~Dm_Valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants/responses are queued when stimulus
// is driven and compared by a bus agent that also models the memory.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int MAX_DM_BURST = 4;
  localparam int TIMEOUT      = 8;

  logic              Clk, Reset;
  logic              If_Req, If_Flush, If_Valid;
  logic [ADDR_W-1:0] If_Addr;
  logic [DATA_W-1:0] If_Rdata;
  logic              Dm_Req, Dm_We, Dm_Valid;
  logic [2:0]        Dm_Func3;
  logic [ADDR_W-1:0] Dm_Addr;
  logic [DATA_W-1:0] Dm_Wdata, Dm_Rdata;
  logic              Mem_Req, Mem_We, Mem_Ready;
  logic [2:0]        Mem_Func3;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Wdata, Mem_Rdata;
  logic              Stall_Pipe, Bus_Err;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DM_BURST(MAX_DM_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .If_Req(If_Req), .If_Addr(If_Addr), .If_Flush(If_Flush),
    .If_Rdata(If_Rdata), .If_Valid(If_Valid),
    .Dm_Req(Dm_Req), .Dm_We(Dm_We), .Dm_Func3(Dm_Func3), .Dm_Addr(Dm_Addr),
    .Dm_Wdata(Dm_Wdata), .Dm_Rdata(Dm_Rdata), .Dm_Valid(Dm_Valid),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Func3(Mem_Func3), .Mem_Addr(Mem_Addr),
    .Mem_Wdata(Mem_Wdata), .Mem_Ready(Mem_Ready), .Mem_Rdata(Mem_Rdata),
    .Stall_Pipe(Stall_Pipe), .Bus_Err(Bus_Err)
  );

  typedef struct {
    logic        dm;
    logic [31:0] addr;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic        dm;
    logic [31:0] data;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     lat = 1;          // busy cycle in which memory answers; 0 = never
  logic   spurious = 1'b0;  // drive Mem_Ready while the bus is idle
  int     n_if_valid = 0;
  int     n_dm_valid = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic exp_fetch(input logic [31:0] a, input bit resp);
    grant_t g;
    resp_t  r;
    g.dm = 1'b0; g.addr = a; g.we = 1'b0; g.f3 = 3'b010; g.wdata = '0;
    gq.push_back(g);
    if (resp) begin
      r.dm = 1'b0; r.data = mem_word(a);
      rq.push_back(r);
    end
  endtask

  task automatic exp_data(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit resp);
    grant_t g;
    resp_t  r;
    g.dm = 1'b1; g.addr = a; g.we = we; g.f3 = f3; g.wdata = we ? wd : 32'h0;
    gq.push_back(g);
    if (resp) begin
      r.dm = 1'b1; r.data = mem_word(a);
      rq.push_back(r);
    end
  endtask

  task automatic take_valid(input logic dm, input logic [31:0] data);
    resp_t r;
    if (rq.size() == 0) begin
      check(dm ? "dm_valid_expected" : "if_valid_expected", 32'(rq.size()), 1);
      return;
    end
    r = rq.pop_front();
    check("valid_owner", 32'(dm), 32'(r.dm));
    check(dm ? "dm_rdata" : "if_rdata", data, r.data);
  endtask

  // Bus agent: checks each grant against the scoreboard, models memory latency/data,
  // and checks every completion pulse.
  initial begin : bus_agent
    logic   prev_req;
    int     cyc;
    grant_t cur;
    prev_req = 1'b0;
    cyc = 0;
    Mem_Ready = 1'b0;
    Mem_Rdata = '0;
    cur.dm = 1'b0; cur.addr = '0; cur.we = 1'b0; cur.f3 = '0; cur.wdata = '0;
    forever begin
      @(negedge Clk);
      if (Mem_Req && !prev_req) begin
        if (gq.size() == 0) begin
          check("grant_expected", 32'(gq.size()), 1);
        end else begin
          cur = gq.pop_front();
          check("grant_addr", Mem_Addr, cur.addr);
          check("grant_we", 32'(Mem_We), 32'(cur.we));
          check("grant_wdata", Mem_Wdata, cur.wdata);
          if (cur.dm) check("grant_func3", 32'(Mem_Func3), 32'(cur.f3));
        end
      end
      cyc = Mem_Req ? cyc + 1 : 0;
      if (If_Valid) begin n_if_valid++; take_valid(1'b0, If_Rdata); end
      if (Dm_Valid) begin n_dm_valid++; take_valid(1'b1, Dm_Rdata); end
      if (Mem_Req && lat != 0 && cyc == lat) begin
        check("addr_hold", Mem_Addr, cur.addr);
        Mem_Ready = 1'b1;
        Mem_Rdata = mem_word(Mem_Addr);
      end else if (!Mem_Req && spurious) begin
        Mem_Ready = 1'b1;
        Mem_Rdata = 32'hBAD0_BAD0;
      end else begin
        Mem_Ready = 1'b0;
        Mem_Rdata = $urandom;
      end
      prev_req = Mem_Req;
    end
  end

  // Requesters: raise Req, wait (bounded) for Valid, drop Req in the Valid cycle.
  task automatic fetch_txn(input logic [31:0] a, output int n);
    If_Addr = a;
    If_Req  = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (!If_Valid && n < 100);
    check("if_valid_seen", 32'(If_Valid), 1);
    If_Req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int n);
    Dm_We = we; Dm_Func3 = f3; Dm_Addr = a; Dm_Wdata = wd;
    Dm_Req = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (!Dm_Valid && n < 100);
    check("dm_valid_seen", 32'(Dm_Valid), 1);
    Dm_Req = 1'b0;
  endtask

  initial begin : main
    int n, nf, nd, base;
    Reset = 1'b1; If_Req = 1'b0; If_Addr = '0; If_Flush = 1'b0;
    Dm_Req = 1'b0; Dm_We = 1'b0; Dm_Func3 = '0; Dm_Addr = '0; Dm_Wdata = '0;

    // Reset state, with requests pending to show the stall is held low too
    #1 Reset = 1'b0; If_Req = 1'b1; Dm_Req = 1'b1;
    #2;
    check("rst_mem_req", 32'(Mem_Req), 0);
    check("rst_if_valid", 32'(If_Valid), 0);
    check("rst_dm_valid", 32'(Dm_Valid), 0);
    check("rst_bus_err", 32'(Bus_Err), 0);
    check("rst_stall", 32'(Stall_Pipe), 0);
    check("rst_mem_addr", Mem_Addr, 0);
    If_Req = 1'b0; Dm_Req = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // Fetch only, memory answers in the second busy cycle
    lat = 2;
    exp_fetch(32'h100, 1);
    fork
      fetch_txn(32'h100, n);
      begin @(negedge Clk); #1 check("stall_while_busy", 32'(Stall_Pipe), 1); end
    join
    check("fetch_latency", n, 3);
    #1 check("stall_after_valid", 32'(Stall_Pipe), 0);
    @(negedge Clk);
    check("if_valid_one_cycle", 32'(If_Valid), 0);

    // Minimum Req-to-Valid
    lat = 1;
    exp_fetch(32'h104, 1);
    fetch_txn(32'h104, n);
    check("fetch_min_latency", n, 2);
    @(negedge Clk);

    // Simultaneous requests: store first, fetch right after the turnaround
    exp_data(1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, 1);
    exp_fetch(32'h108, 1);
    fork
      data_txn(1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, nd);
      fetch_txn(32'h108, nf);
    join
    check("sim_dm_latency", nd, 2);
    check("sim_if_latency", nf, 5);
    @(negedge Clk);

    // Starvation: data held back-to-back, fetch waiting
    for (int i = 0; i < 4; i++) exp_data(1'b0, 3'b000, 32'h800 + 32'(4 * i), 32'h0, 1);
    exp_fetch(32'h300, 1);
    for (int i = 4; i < 6; i++) exp_data(1'b0, 3'b000, 32'h800 + 32'(4 * i), 32'h0, 1);
    fork
      begin
        for (int i = 0; i < 6; i++) data_txn(1'b0, 3'b000, 32'h800 + 32'(4 * i), 32'h0, nd);
      end
      fetch_txn(32'h300, nf);
    join
    check("starve_fetch_latency", nf, 14);
    @(negedge Clk);

    // Flush during BUSY_IF: bus completes silently, new address fetched
    lat = 3;
    exp_fetch(32'h400, 0);
    exp_fetch(32'h500, 1);
    base = n_if_valid;
    If_Addr = 32'h400; If_Req = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (!Mem_Req && n < 20);
    check("flush_grant_seen", 32'(Mem_Req), 1);
    If_Flush = 1'b1; If_Addr = 32'h500;
    @(negedge Clk);
    If_Flush = 1'b0;
    n = 0;
    do begin @(negedge Clk); n++; end while (!If_Valid && n < 100);
    check("flush_refetch_latency", n, 6);
    If_Req = 1'b0;
    @(negedge Clk);
    check("flush_single_valid", n_if_valid - base, 1);
    check("flush_valid_pulse", 32'(If_Valid), 0);

    // Timeout on a load, then a successful retry
    lat = 0;
    exp_data(1'b0, 3'b010, 32'h600, 32'h0, 0);
    base = n_dm_valid;
    Dm_We = 1'b0; Dm_Func3 = 3'b010; Dm_Addr = 32'h600; Dm_Wdata = 32'h1111_2222; Dm_Req = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (!Mem_Req && n < 20);
    check("to_grant_seen", 32'(Mem_Req), 1);
    n = 0;
    do begin @(negedge Clk); n++; end while (!Bus_Err && n < 40);
    check("to_bus_err_delay", n, 8);
    check("to_mem_req_dropped", 32'(Mem_Req), 0);
    check("to_no_dm_valid", 32'(Dm_Valid), 0);
    Dm_Req = 1'b0;
    @(negedge Clk);
    check("to_bus_err_pulse", 32'(Bus_Err), 0);
    check("to_idle", 32'(Mem_Req), 0);
    check("to_no_valid_total", n_dm_valid - base, 0);
    lat = 1;
    exp_data(1'b0, 3'b010, 32'h600, 32'h0, 1);
    data_txn(1'b0, 3'b010, 32'h600, 32'h0, nd);
    check("to_retry_latency", nd, 2);
    @(negedge Clk);

    // Mem_Ready while idle is ignored
    base = n_if_valid + n_dm_valid;
    spurious = 1'b1;
    repeat (2) @(negedge Clk);
    spurious = 1'b0;
    repeat (3) @(negedge Clk);
    check("spurious_no_valid", n_if_valid + n_dm_valid - base, 0);
    check("spurious_no_req", 32'(Mem_Req), 0);

    // Asynchronous reset in BUSY_DM, then a fresh store
    lat = 0;
    exp_data(1'b0, 3'b001, 32'h700, 32'h0, 0);
    Dm_We = 1'b0; Dm_Func3 = 3'b001; Dm_Addr = 32'h700; Dm_Req = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (!Mem_Req && n < 20);
    check("rstmid_grant_seen", 32'(Mem_Req), 1);
    #2 Reset = 1'b0;
    #1;
    check("rstmid_mem_req", 32'(Mem_Req), 0);
    check("rstmid_stall", 32'(Stall_Pipe), 0);
    check("rstmid_dm_valid", 32'(Dm_Valid), 0);
    check("rstmid_mem_addr", Mem_Addr, 0);
    Dm_Req = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    lat = 1;
    exp_data(1'b1, 3'b000, 32'h704, 32'h1234_5678, 1);
    data_txn(1'b1, 3'b000, 32'h704, 32'h1234_5678, nd);
    check("rstmid_fresh_latency", nd, 2);

    repeat (3) @(negedge Clk);
    check("grants_left", 32'(gq.size()), 0);
    check("resps_left", 32'(rq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
